// File: rtl/i2c_init_seq.sv
// i2c_init_seq: boot-time register-write sequencer for the i2c master.
// Reads (regAdr, data) pairs from a synchronous table and, for each entry,
// issues START + {DEV_ADR,W}, regAdr, data + STOP on the controller's cmd*
// interface. Each entry has bounded retry and a per-byte watchdog.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start              pulse, begins the sequence at entry 0 (ignored while busy)
//   tblAdr / tblData   table address out, {regAdr,data} back one cycle later
//   cmdBegin/cmdClear  one-cycle pulses toward the byte controller
//   cmdBit*/cmdByteWr  byte-operation flags and byte, stable between cmdBegins
//   cmdRdy/cmdErr      byte completion and status from the controller
//   cmdBusy            controller active
//   busy/done/fail     sequence status; failIdx = entry that failed
module i2c_init_seq #(
  parameter int unsigned N_ENTRIES  = 16,
  parameter logic [6:0]  DEV_ADR    = 7'h1A,
  parameter int unsigned RETRY_MAX  = 3,
  parameter int unsigned TIMEOUT    = 65535,
  parameter int unsigned GAP_CYCLES = 64,
  localparam int unsigned IDX_W     = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [IDX_W-1:0] tblAdr,
  input  logic [15:0]      tblData,
  output logic             cmdBegin,
  output logic             cmdClear,
  output logic             cmdBitStart,
  output logic             cmdBitWr,
  output logic             cmdBitAck,
  output logic             cmdBitStop,
  output logic [7:0]       cmdByteWr,
  input  logic             cmdRdy,
  input  logic [1:0]       cmdErr,
  input  logic             cmdBusy,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [IDX_W-1:0] failIdx
);

  localparam int unsigned RT_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned GP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SEND_DEV, S_WAIT_DEV, S_SEND_REG, S_WAIT_REG,
    S_SEND_DAT, S_WAIT_DAT, S_GAP, S_CLEAR, S_FAIL
  } state_t;

  state_t           r_state, w_state;
  logic [IDX_W-1:0] r_idx, w_idx;
  logic [RT_W-1:0]  r_retry, w_retry;
  logic [WD_W-1:0]  r_wdog, w_wdog;
  logic [GP_W-1:0]  r_gap, w_gap;
  logic [7:0]       r_reg, w_reg, r_dat, w_dat;
  logic             r_cmd_begin, w_cmd_begin, r_cmd_clear, w_cmd_clear;
  logic             r_bit_start, w_bit_start, r_bit_wr, w_bit_wr;
  logic             r_bit_ack, w_bit_ack, r_bit_stop, w_bit_stop;
  logic [7:0]       r_byte_wr, w_byte_wr;
  logic             r_busy, w_busy, r_done, w_done, r_fail, w_fail;
  logic [IDX_W-1:0] r_fail_idx, w_fail_idx;

  // Next-state and next-output logic
  always_comb begin
    w_state     = r_state;
    w_idx       = r_idx;
    w_retry     = r_retry;
    w_wdog      = r_wdog;
    w_gap       = r_gap;
    w_reg       = r_reg;
    w_dat       = r_dat;
    w_cmd_begin = 1'b0;
    w_cmd_clear = 1'b0;
    w_bit_start = r_bit_start;
    w_bit_wr    = r_bit_wr;
    w_bit_ack   = r_bit_ack;
    w_bit_stop  = r_bit_stop;
    w_byte_wr   = r_byte_wr;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_fail      = r_fail;
    w_fail_idx  = r_fail_idx;

    case (r_state)
      S_IDLE, S_FAIL: begin
        if (start) begin
          w_fail     = 1'b0;
          w_fail_idx = '0;
          w_idx      = '0;
          w_retry    = '0;
          w_busy     = 1'b1;
          w_state    = S_FETCH;
        end
      end
      S_FETCH: w_state = S_LOAD;
      S_LOAD: begin
        w_reg   = tblData[15:8];
        w_dat   = tblData[7:0];
        w_state = S_SEND_DEV;
      end
      S_SEND_DEV, S_SEND_REG, S_SEND_DAT: begin
        if (!cmdBusy) begin
          w_cmd_begin = 1'b1;
          w_wdog      = '0;
          w_bit_wr    = 1'b1;
          w_bit_ack   = 1'b0;
          w_bit_start = 1'b0;
          w_bit_stop  = 1'b0;
          case (r_state)
            S_SEND_DEV: begin
              w_byte_wr   = {DEV_ADR, 1'b0};
              w_bit_start = 1'b1;
              w_state     = S_WAIT_DEV;
            end
            S_SEND_REG: begin
              w_byte_wr = r_reg;
              w_state   = S_WAIT_REG;
            end
            default: begin
              w_byte_wr  = r_dat;
              w_bit_stop = 1'b1;
              w_state    = S_WAIT_DAT;
            end
          endcase
        end
      end
      S_WAIT_DEV, S_WAIT_REG, S_WAIT_DAT: begin
        // cmdRdy wins over a watchdog expiry in the same cycle
        if (cmdRdy) begin
          if (cmdErr == 2'b00) begin
            case (r_state)
              S_WAIT_DEV: w_state = S_SEND_REG;
              S_WAIT_REG: w_state = S_SEND_DAT;
              default: begin
                w_gap   = '0;
                w_state = S_GAP;
              end
            endcase
          end else begin
            w_cmd_clear = 1'b1;
            w_state     = S_CLEAR;
          end
        end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
          w_cmd_clear = 1'b1;
          w_state     = S_CLEAR;
        end else begin
          w_wdog = WD_W'(r_wdog + WD_W'(1));
        end
      end
      S_CLEAR: begin
        // cmdClear is high in the first CLEAR cycle; let the controller see it
        if (!r_cmd_clear && !cmdBusy) begin
          if (r_retry < RT_W'(RETRY_MAX)) begin
            w_retry = RT_W'(r_retry + RT_W'(1));
            w_state = S_FETCH;
          end else begin
            w_fail     = 1'b1;
            w_fail_idx = r_idx;
            w_busy     = 1'b0;
            w_state    = S_FAIL;
          end
        end
      end
      S_GAP: begin
        if (r_gap == GP_W'(GAP_CYCLES - 1)) begin
          if (r_idx == IDX_W'(N_ENTRIES - 1)) begin
            w_done  = 1'b1;
            w_busy  = 1'b0;
            w_state = S_IDLE;
          end else begin
            w_idx   = IDX_W'(r_idx + IDX_W'(1));
            w_retry = '0;
            w_state = S_FETCH;
          end
        end else begin
          w_gap = GP_W'(r_gap + GP_W'(1));
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_retry     <= '0;
      r_wdog      <= '0;
      r_gap       <= '0;
      r_reg       <= '0;
      r_dat       <= '0;
      r_cmd_begin <= 1'b0;
      r_cmd_clear <= 1'b0;
      r_bit_start <= 1'b0;
      r_bit_wr    <= 1'b0;
      r_bit_ack   <= 1'b0;
      r_bit_stop  <= 1'b0;
      r_byte_wr   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_idx  <= '0;
    end else begin
      r_state     <= w_state;
      r_idx       <= w_idx;
      r_retry     <= w_retry;
      r_wdog      <= w_wdog;
      r_gap       <= w_gap;
      r_reg       <= w_reg;
      r_dat       <= w_dat;
      r_cmd_begin <= w_cmd_begin;
      r_cmd_clear <= w_cmd_clear;
      r_bit_start <= w_bit_start;
      r_bit_wr    <= w_bit_wr;
      r_bit_ack   <= w_bit_ack;
      r_bit_stop  <= w_bit_stop;
      r_byte_wr   <= w_byte_wr;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_fail      <= w_fail;
      r_fail_idx  <= w_fail_idx;
    end
  end

  assign tblAdr      = r_idx;
  assign cmdBegin    = r_cmd_begin;
  assign cmdClear    = r_cmd_clear;
  assign cmdBitStart = r_bit_start;
  assign cmdBitWr    = r_bit_wr;
  assign cmdBitAck   = r_bit_ack;
  assign cmdBitStop  = r_bit_stop;
  assign cmdByteWr   = r_byte_wr;
  assign busy        = r_busy;
  assign done        = r_done;
  assign fail        = r_fail;
  assign failIdx     = r_fail_idx;

endmodule

// File: tb/tb_i2c_init_seq.sv
// tb_i2c_init_seq: scenario table plus hand-written corner sequences for
// i2c_init_seq, with a behavioural byte controller and a synchronous table.
// Expected cmdBegin bytes/flags are queued per scenario and popped as the
// DUT issues them.
module tb_i2c_init_seq;

  localparam int unsigned N_ENT    = 3;
  localparam int unsigned RETRY    = 3;
  localparam int unsigned TMO      = 100;
  localparam int unsigned GAP      = 8;
  localparam logic [7:0]  DEV_BYTE = 8'h34;   // {7'h1A, W=0}

  logic       clk, reset, start;
  logic [1:0] tblAdr;
  logic [15:0] tblData;
  logic       cmdBegin, cmdClear, cmdBitStart, cmdBitWr, cmdBitAck, cmdBitStop;
  logic [7:0] cmdByteWr;
  logic       cmdRdy, cmdBusy;
  logic [1:0] cmdErr;
  logic       busy, done, fail;
  logic [1:0] failIdx;

  i2c_init_seq #(
    .N_ENTRIES(N_ENT), .DEV_ADR(7'h1A), .RETRY_MAX(RETRY),
    .TIMEOUT(TMO), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .tblAdr(tblAdr), .tblData(tblData),
    .cmdBegin(cmdBegin), .cmdClear(cmdClear),
    .cmdBitStart(cmdBitStart), .cmdBitWr(cmdBitWr),
    .cmdBitAck(cmdBitAck), .cmdBitStop(cmdBitStop),
    .cmdByteWr(cmdByteWr), .cmdRdy(cmdRdy), .cmdErr(cmdErr),
    .cmdBusy(cmdBusy), .busy(busy), .done(done), .fail(fail),
    .failIdx(failIdx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] tbl_at(input int i);
    case (i)
      0:       return 16'h0F00;
      1:       return 16'h1234;
      2:       return 16'h56AB;
      default: return 16'h0000;
    endcase
  endfunction

  // Synchronous table: data valid one cycle after the address
  always @(posedge clk) tblData <= tbl_at(int'(tblAdr));

  // Controller model. mode 0: always ACK; 1: NACK reg byte 0x12 once;
  // 2: bus error on data byte 0xAB forever; 3: never answers.
  int         mode;
  logic [3:0] m_cnt;
  logic       m_pend, m_nack_done;
  logic [1:0] m_err, m_drop;

  always @(posedge clk) begin
    if (reset) begin
      cmdRdy <= 1'b0; cmdErr <= 2'b00; cmdBusy <= 1'b0;
      m_cnt <= '0; m_pend <= 1'b0; m_nack_done <= 1'b0;
      m_err <= 2'b00; m_drop <= 2'd0;
    end else begin
      cmdRdy <= 1'b0;
      cmdErr <= 2'b00;
      if (start) m_nack_done <= 1'b0;
      if (cmdBegin) begin
        cmdBusy <= 1'b1;
        m_cnt   <= 4'd3;
        m_pend  <= (mode != 3);
        if (mode == 1 && cmdByteWr == 8'h12 && !cmdBitStart && !m_nack_done) begin
          m_err <= 2'b01;
          m_nack_done <= 1'b1;
        end else if (mode == 2 && cmdByteWr == 8'hAB && cmdBitStop) begin
          m_err <= 2'b10;
        end else begin
          m_err <= 2'b00;
        end
      end else if (m_pend) begin
        if (m_cnt == 4'd1) begin
          cmdRdy <= 1'b1;
          cmdErr <= m_err;
          m_pend <= 1'b0;
          if (m_err == 2'b00) cmdBusy <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 4'd1;
        end
      end
      if (cmdClear) begin
        m_drop <= 2'd2;
        m_pend <= 1'b0;
      end else if (m_drop != 2'd0) begin
        m_drop <= m_drop - 2'd1;
        if (m_drop == 2'd1) cmdBusy <= 1'b0;
      end
    end
  end

  typedef struct {
    logic [7:0] b;
    logic       st;
    logic       sp;
  } beg_t;

  typedef struct {
    string      name;
    int         mode;
    int         restart_at;
    int         n_beg;
    int         n_clr;
    int         n_done;
    logic       fail;
    logic [1:0] fidx;
  } vec_t;

  beg_t sb[$];
  vec_t vecs[5];

  int n_cmp, n_mis;
  int cyc, n_begin, n_clear, n_done, last_begin_cyc, last_ent_end;
  bit last_stop;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One clock: sample outputs 1 time unit after the edge and score them
  task automatic step();
    beg_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (cmdBegin) begin
      n_begin++;
      if (sb.size() == 0) begin
        chk("begin_unexpected", 32'(cmdByteWr), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("begin_byte",  32'(cmdByteWr),   32'(e.b));
        chk("begin_start", 32'(cmdBitStart), 32'(e.st));
        chk("begin_stop",  32'(cmdBitStop),  32'(e.sp));
        chk("begin_wr",    32'(cmdBitWr),    32'd1);
        chk("begin_ack",   32'(cmdBitAck),   32'd0);
      end
      if (cmdBitStart && last_ent_end >= 0) begin
        chk("gap_ok", 32'(cyc - last_ent_end >= int'(GAP)), 32'd1);
        last_ent_end = -1;
      end
      last_begin_cyc = cyc;
      last_stop = cmdBitStop;
    end
    if (cmdRdy && cmdErr == 2'b00 && last_stop) last_ent_end = cyc;
    if (cmdClear) begin
      n_clear++;
      if (mode == 3) chk("wdog_clear_lat", 32'(cyc - last_begin_cyc), 32'(TMO));
    end
    if (done) begin
      n_done++;
      chk("busy_at_done", 32'(busy), 32'd0);
    end
  endtask

  task automatic push_ent(input int e, input int n);
    logic [15:0] t;
    t = tbl_at(e);
    sb.push_back('{b: DEV_BYTE, st: 1'b1, sp: 1'b0});
    if (n >= 2) sb.push_back('{b: t[15:8], st: 1'b0, sp: 1'b0});
    if (n >= 3) sb.push_back('{b: t[7:0], st: 1'b0, sp: 1'b1});
  endtask

  task automatic plan(input int m);
    for (int e = 0; e < int'(N_ENT); e++) begin
      if (m == 3) begin
        if (e == 0) for (int a = 0; a <= int'(RETRY); a++) push_ent(0, 1);
      end else if (m == 1 && e == 1) begin
        push_ent(1, 2);
        push_ent(1, 3);
      end else if (m == 2 && e == 2) begin
        for (int a = 0; a <= int'(RETRY); a++) push_ent(2, 3);
      end else begin
        push_ent(e, 3);
      end
    end
  endtask

  task automatic clear_counts();
    n_begin = 0; n_clear = 0; n_done = 0;
    last_begin_cyc = 0; last_ent_end = -1; last_stop = 1'b0;
    sb.delete();
  endtask

  task automatic launch();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Run until done/fail is seen, then a few more cycles to catch extra pulses
  task automatic run_to_end(input int restart_at);
    bit fin, restarted;
    int k, post;
    fin = 1'b0; restarted = 1'b0; k = 0; post = 0;
    while (k < 4000 && post < 6) begin
      if (restart_at > 0 && !restarted && n_begin == restart_at) begin
        chk("busy_at_restart", 32'(busy), 32'd1);
        start = 1'b1;
        restarted = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      if (done || fail) fin = 1'b1;
      if (fin) post++;
      k++;
    end
    start = 1'b0;
    chk("run_finished", 32'(fin), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmdBegin"},  32'(cmdBegin),    32'd0);
    chk({tag, "_cmdClear"},  32'(cmdClear),    32'd0);
    chk({tag, "_bitStart"},  32'(cmdBitStart), 32'd0);
    chk({tag, "_bitWr"},     32'(cmdBitWr),    32'd0);
    chk({tag, "_bitAck"},    32'(cmdBitAck),   32'd0);
    chk({tag, "_bitStop"},   32'(cmdBitStop),  32'd0);
    chk({tag, "_byteWr"},    32'(cmdByteWr),   32'd0);
    chk({tag, "_tblAdr"},    32'(tblAdr),      32'd0);
    chk({tag, "_busy"},      32'(busy),        32'd0);
    chk({tag, "_done"},      32'(done),        32'd0);
    chk({tag, "_fail"},      32'(fail),        32'd0);
    chk({tag, "_failIdx"},   32'(failIdx),     32'd0);
  endtask

  initial begin
    int n;
    vecs[0] = '{name: "ack3",      mode: 0, restart_at: 0, n_beg: 9,  n_clr: 0, n_done: 1, fail: 1'b0, fidx: 2'd0};
    vecs[1] = '{name: "nack_once", mode: 1, restart_at: 0, n_beg: 11, n_clr: 1, n_done: 1, fail: 1'b0, fidx: 2'd0};
    vecs[2] = '{name: "nack_e2",   mode: 2, restart_at: 0, n_beg: 18, n_clr: 4, n_done: 0, fail: 1'b1, fidx: 2'd2};
    vecs[3] = '{name: "no_rdy",    mode: 3, restart_at: 0, n_beg: 4,  n_clr: 4, n_done: 0, fail: 1'b1, fidx: 2'd0};
    vecs[4] = '{name: "restart",   mode: 0, restart_at: 2, n_beg: 9,  n_clr: 0, n_done: 1, fail: 1'b0, fidx: 2'd0};

    n_cmp = 0; n_mis = 0; cyc = 0; mode = 0;
    reset = 1'b1; start = 1'b0;
    clear_counts();
    repeat (3) step();
    chk_reset_vals("por");
    reset = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      mode = vecs[i].mode;
      clear_counts();
      plan(mode);
      launch();
      chk({vecs[i].name, "_busy_rise"}, 32'(busy), 32'd1);
      run_to_end(vecs[i].restart_at);
      chk({vecs[i].name, "_begins"},  32'(n_begin),   32'(vecs[i].n_beg));
      chk({vecs[i].name, "_clears"},  32'(n_clear),   32'(vecs[i].n_clr));
      chk({vecs[i].name, "_dones"},   32'(n_done),    32'(vecs[i].n_done));
      chk({vecs[i].name, "_fail"},    32'(fail),      32'(vecs[i].fail));
      chk({vecs[i].name, "_failIdx"}, 32'(failIdx),   32'(vecs[i].fidx));
      chk({vecs[i].name, "_busy_end"},32'(busy),      32'd0);
      chk({vecs[i].name, "_sb_left"}, 32'(sb.size()), 32'd0);
    end

    // Reset while the register byte is in flight
    mode = 0;
    clear_counts();
    plan(0);
    launch();
    n = 0;
    while (n_begin < 2 && n < 50) begin
      step();
      n++;
    end
    chk("reached_wait_reg", 32'(n_begin), 32'd2);
    reset = 1'b1;
    step();
    chk_reset_vals("mid");
    reset = 1'b0;
    step();

    // start -> first cmdBegin after FETCH, LOAD, SEND_DEV
    clear_counts();
    plan(0);
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (!cmdBegin && n < 20) begin
      step();
      n++;
    end
    chk("start_to_begin_edges", 32'(n), 32'd4);
    run_to_end(0);
    chk("post_reset_begins", 32'(n_begin), 32'd9);
    chk("post_reset_clears", 32'(n_clear), 32'd0);
    chk("post_reset_dones",  32'(n_done),  32'd1);
    chk("post_reset_fail",   32'(fail),    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
